// File: rtl/crc_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc_mac_pkg
//  Description : Shared CRC32 definitions for the Ethernet MAC transmit and
//                receive paths: reflected polynomial, good-frame residue,
//                FCS length and the byte-at-a-time CRC update function.
//  Revision    : 1.0 - initial release
// ============================================================================
package crc_mac_pkg;

  localparam logic [31:0] CRC32_POLYNOMIAL = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE    = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;
  localparam int          FCS_BYTES        = 4;

  // One byte of a streamed frame as it sits in the output register.
  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } axis_beat_t;

  // Reflected CRC32 update for one byte, LSB first. Unrolled into eight
  // shift/conditional-xor stages by synthesis.
  function automatic logic [31:0] crc32_byte(
    input logic [7:0]  data,
    input logic [31:0] remainder,
    input logic [31:0] poly
  );
    logic [31:0] c;
    c = remainder ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

endpackage : crc_mac_pkg
`default_nettype wire

// File: rtl/crc_check_mac_if.sv
`default_nettype none
// ============================================================================
//  Module      : crc_check_mac_if
//  Description : Byte-wide AXI-Stream bundle (tdata/tvalid/tready/tlast/
//                tuser).
//  Modports    : master - drives tdata/tvalid/tlast/tuser, samples tready
//                slave  - samples tdata/tvalid/tlast/tuser, drives tready
//  Revision    : 1.0 - initial release
// ============================================================================
interface crc_check_mac_if;
  import crc_mac_pkg::*;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface : crc_check_mac_if
`default_nettype wire

// File: rtl/crc_check_mac_byte_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : byte_delay_line
//  Description : DEPTH-entry byte shift register with an occupancy count.
//                Every push shifts the line towards entry 0, so once full
//                entry 0 holds the oldest byte. Flush only zeroes the count;
//                stale entries are shifted out by the next frame.
//  Ports       : clock, aresetn      - clock, async active-low reset
//                push_i, data_i      - shift data_i in
//                flush_i             - restart occupancy (wins over push)
//                oldest_o            - entry 0, valid when full_o
//                newest_o            - entries DEPTH-1..1, newest in MSBs
//                full_o              - DEPTH bytes held
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_delay_line
  import crc_mac_pkg::*;
#(
  parameter int DEPTH = FCS_BYTES
) (
  input  wire logic                   clock,
  input  wire logic                   aresetn,
  input  wire logic                   push_i,
  input  wire logic                   flush_i,
  input  wire logic [7:0]             data_i,
  output logic      [7:0]             oldest_o,
  output logic      [8*(DEPTH-1)-1:0] newest_o,
  output logic                        full_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    entry_q [DEPTH];
  logic [7:0]    entry_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign full_o   = (count_q == CW'(DEPTH));
  assign oldest_o = entry_q[0];

  generate
    for (genvar gi = 0; gi < DEPTH - 1; gi++) begin : g_newest
      assign newest_o[8*gi +: 8] = entry_q[gi+1];
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    count_d = count_q;

    if (push_i) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        entry_d[i] = entry_q[i+1];
      end
      entry_d[DEPTH-1] = data_i;
      // Once full, a push pops the oldest at the same time: count holds.
      if (!full_o) begin
        count_d = count_q + CW'(1);
      end
    end

    if (flush_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= 8'h00;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule : byte_delay_line
`default_nettype wire

// File: rtl/crc_check_mac.sv
`default_nettype none
// ============================================================================
//  Module      : crc_check_mac
//  Description : Receive-side Ethernet FCS checker. Holds the last four
//                bytes of the frame back in a delay line so the FCS can be
//                stripped, runs the reflected CRC32 over data+FCS and
//                compares the remainder against the fixed residue. Bad CRC
//                or upstream error is reported on tuser of the last payload
//                byte and via status pulses.
//  Ports       : clock, aresetn - clock, async active-low reset
//                saxis          - input stream (frame incl. 4-byte FCS)
//                maxis          - output stream (payload only)
//                fcs_rx         - FCS of last completed frame {b3,b2,b1,b0}
//                frame_done     - pulse per completed frame (incl. runts)
//                crc_error      - pulse, completed frame failed residue
//                runt           - pulse, frame of <= 4 bytes discarded
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_check_mac
  import crc_mac_pkg::*;
#(
  parameter logic [31:0] POLYNOMIAL = CRC32_POLYNOMIAL,
  parameter logic [31:0] RESIDUE    = CRC32_RESIDUE
) (
  input  wire logic        clock,
  input  wire logic        aresetn,
  crc_check_mac_if.slave   saxis,
  crc_check_mac_if.master  maxis,
  output logic [31:0]      fcs_rx,
  output logic             frame_done,
  output logic             crc_error,
  output logic             runt
);

  logic        accept;
  logic        load;
  logic        full;
  logic        crc_bad;
  logic [7:0]  oldest;
  logic [23:0] newest;
  logic [31:0] crc_next;

  logic [31:0] rem_q,  rem_d;
  logic        err_q,  err_d;
  axis_beat_t  beat_q, beat_d;
  logic        tvalid_q, tvalid_d;
  logic [31:0] fcs_q,  fcs_d;
  logic        done_q, done_d;
  logic        crcerr_q, crcerr_d;
  logic        runt_q, runt_d;

  // Single output register: upstream may advance whenever it is empty or
  // being drained this cycle.
  assign saxis.tready = ~tvalid_q | maxis.tready;
  assign accept       = saxis.tvalid & saxis.tready;
  assign load         = accept & full;

  assign crc_next = crc32_byte(saxis.tdata, rem_q, POLYNOMIAL);
  assign crc_bad  = (crc_next != RESIDUE);

  byte_delay_line #(
    .DEPTH (FCS_BYTES)
  ) u_delay (
    .clock    (clock),
    .aresetn  (aresetn),
    .push_i   (accept),
    .flush_i  (accept & saxis.tlast),
    .data_i   (saxis.tdata),
    .oldest_o (oldest),
    .newest_o (newest),
    .full_o   (full)
  );

  always_comb begin
    rem_d    = rem_q;
    err_d    = err_q;
    beat_d   = beat_q;
    tvalid_d = tvalid_q;
    fcs_d    = fcs_q;
    done_d   = 1'b0;
    crcerr_d = 1'b0;
    runt_d   = 1'b0;

    if (accept) begin
      if (saxis.tlast) begin
        rem_d  = CRC32_INIT;
        err_d  = 1'b0;
        done_d = 1'b1;
        if (full) begin
          crcerr_d = crc_bad;
          fcs_d    = {saxis.tdata, newest};
        end else begin
          runt_d = 1'b1;
        end
      end else begin
        rem_d = crc_next;
        err_d = err_q | saxis.tuser;
      end
    end

    // Reload takes priority over drain so a back-to-back byte is not lost.
    if (load) begin
      tvalid_d    = 1'b1;
      beat_d.data = oldest;
      beat_d.last = saxis.tlast;
      beat_d.user = saxis.tlast & (err_q | saxis.tuser | crc_bad);
    end else if (tvalid_q && maxis.tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      rem_q    <= CRC32_INIT;
      err_q    <= 1'b0;
      beat_q   <= '0;
      tvalid_q <= 1'b0;
      fcs_q    <= 32'h0;
      done_q   <= 1'b0;
      crcerr_q <= 1'b0;
      runt_q   <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      err_q    <= err_d;
      beat_q   <= beat_d;
      tvalid_q <= tvalid_d;
      fcs_q    <= fcs_d;
      done_q   <= done_d;
      crcerr_q <= crcerr_d;
      runt_q   <= runt_d;
    end
  end

  assign maxis.tdata  = beat_q.data;
  assign maxis.tlast  = beat_q.last;
  assign maxis.tuser  = beat_q.user;
  assign maxis.tvalid = tvalid_q;

  assign fcs_rx     = fcs_q;
  assign frame_done = done_q;
  assign crc_error  = crcerr_q;
  assign runt       = runt_q;

endmodule : crc_check_mac
`default_nettype wire

// File: tb/tb_crc_check_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc_check_mac
//  Description : Scoreboard testbench for crc_check_mac. Expected payload
//                beats and per-frame status are queued when a frame is
//                driven and compared as the DUT emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_check_mac;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  typedef struct {
    logic        r;
    logic        c;
    logic [31:0] f;
  } stat_t;

  logic        clock = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] fcs_rx;
  logic        frame_done;
  logic        crc_error;
  logic        runt;

  int          n_checks = 0;
  int          n_errors = 0;
  beat_t       exp_q[$];
  stat_t       stat_q[$];
  logic [31:0] last_fcs = 32'h0;
  bit          ready_rand = 1'b0;
  bit          sb_ignore = 1'b0;
  beat_t       mon_b;
  stat_t       mon_s;

  always #5 clock = ~clock;

  crc_check_mac_if s_if ();
  crc_check_mac_if m_if ();

  crc_check_mac dut (
    .clock      (clock),
    .aresetn    (aresetn),
    .saxis      (s_if),
    .maxis      (m_if),
    .fcs_rx     (fcs_rx),
    .frame_done (frame_done),
    .crc_error  (crc_error),
    .runt       (runt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC32 (IEEE 802.3), returns the value sent as FCS.
  function automatic logic [31:0] crc_ref(input byte_q_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[k]) begin
      for (int j = 0; j < 8; j++) begin
        if ((c[0] ^ q[k][j]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
        else                          c = c >> 1;
      end
    end
    return ~c;
  endfunction

  function automatic byte_q_t with_fcs(input byte_q_t p);
    byte_q_t     q;
    logic [31:0] f;
    q = p;
    f = crc_ref(p);
    for (int k = 0; k < 4; k++) q.push_back(f[8*k +: 8]);
    return q;
  endfunction

  // Output side: randomise tready and score every beat/status pulse. All
  // values are stable between this negedge and the next posedge.
  always @(negedge clock) begin
    m_if.tready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (aresetn && !sb_ignore) begin
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {m_if.tdata, m_if.tlast}, 0);
        end else begin
          mon_b = exp_q.pop_front();
          chk("tdata", m_if.tdata, mon_b.d);
          chk("tlast", m_if.tlast, mon_b.l);
          if (mon_b.l) chk("tuser_on_last", m_if.tuser, mon_b.u);
        end
      end
      if (frame_done) begin
        if (stat_q.size() == 0) begin
          chk("unexpected_frame_done", frame_done, 0);
        end else begin
          mon_s = stat_q.pop_front();
          chk("runt", runt, mon_s.r);
          chk("crc_error", crc_error, mon_s.c);
          chk("fcs_rx", fcs_rx, mon_s.f);
        end
      end else if (crc_error || runt) begin
        chk("orphan_status_pulse", {crc_error, runt}, 0);
      end
    end
  end

  // Drive bytes starting at a negedge; returns at a negedge after the last
  // byte has been accepted.
  task automatic send(input byte_q_t q, input bit with_last, input int err_idx, input int gap_max);
    int t;
    for (int i = 0; i < q.size(); i++) begin
      s_if.tvalid = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge clock);
      s_if.tdata  = q[i];
      s_if.tlast  = with_last && (i == q.size() - 1);
      s_if.tuser  = (i == err_idx);
      s_if.tvalid = 1'b1;
      #1;
      t = 0;
      while (!s_if.tready) begin
        @(negedge clock);
        #1;
        t++;
        if (t > 1000) begin
          chk("input_stall_timeout", t, 0);
          $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
          $fatal(1, "input stalled");
        end
      end
      @(negedge clock);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  // Queue the expectations for a complete frame (data + FCS), then drive it.
  task automatic send_frame(input byte_q_t q, input int err_idx, input int gap_max);
    int          n;
    byte_q_t     pay;
    logic [31:0] f;
    beat_t       b;
    stat_t       s;
    bit          bad;
    n = q.size();
    if (n <= 4) begin
      s.r = 1'b1; s.c = 1'b0; s.f = last_fcs;
      stat_q.push_back(s);
    end else begin
      for (int k = 0; k < n - 4; k++) pay.push_back(q[k]);
      f   = {q[n-1], q[n-2], q[n-3], q[n-4]};
      bad = (crc_ref(pay) != f);
      for (int k = 0; k < n - 4; k++) begin
        b.d = q[k];
        b.l = (k == n - 5);
        b.u = (k == n - 5) && (bad || err_idx >= 0);
        exp_q.push_back(b);
      end
      s.r = 1'b0; s.c = bad; s.f = f;
      stat_q.push_back(s);
      last_fcs = f;
    end
    send(q, 1'b1, err_idx, gap_max);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || stat_q.size() != 0) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    chk({tag, "_beats_left"}, exp_q.size(), 0);
    chk({tag, "_status_left"}, stat_q.size(), 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, m_if.tvalid, 0);
    chk({tag, "_tdata"}, m_if.tdata, 0);
    chk({tag, "_tlast"}, m_if.tlast, 0);
    chk({tag, "_tuser"}, m_if.tuser, 0);
    chk({tag, "_fcs_rx"}, fcs_rx, 0);
    chk({tag, "_pulses"}, {frame_done, crc_error, runt}, 0);
  endtask

  initial begin
    #2_000_000;
    chk("watchdog", 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte_q_t p, q;
    int      len;
    s_if.tdata  = 8'h00;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    aresetn = 1'b1;
    @(negedge clock);

    // 1: "123456789" with its standard FCS
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    send_frame(q, -1, 0);
    drain("t1");
    chk("t1_fcs_value", fcs_rx, 32'hCBF43926);

    // 2: corrupted payload, original FCS
    q[4] = 8'h36;
    send_frame(q, -1, 0);
    drain("t2");

    // 3: minimal frame, then a runt
    q = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
    send_frame(q, -1, 0);
    drain("t3a");
    chk("t3_fcs_value", fcs_rx, 32'hD202EF8D);
    q = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(q, -1, 0);
    drain("t3b");

    // 4: upstream error on byte 33, good CRC
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    send_frame(q, 2, 1);
    drain("t4");

    // 5: random good frames, random gaps and backpressure
    ready_rand = 1'b1;
    for (int f = 0; f < 100; f++) begin
      p = {};
      len = $urandom_range(1, 24);
      for (int k = 0; k < len; k++) p.push_back(8'($urandom_range(0, 255)));
      send_frame(with_fcs(p), -1, ($urandom_range(0, 1) == 0) ? 0 : 3);
    end
    drain("t5");
    ready_rand = 1'b0;

    // 6: reset mid-frame, then a clean frame
    sb_ignore = 1'b1;
    q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    send(q, 1'b0, -1, 0);
    aresetn = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    repeat (2) @(negedge clock);
    check_reset_outputs("t6_rst_hold");
    aresetn = 1'b1;
    @(negedge clock);
    sb_ignore = 1'b0;
    last_fcs = 32'h0;
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    send_frame(q, -1, 0);
    drain("t6");
    chk("t6_fcs_value", fcs_rx, 32'hCBF43926);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_crc_check_mac
`default_nettype wire
